// File: rtl/grid_reader_if.sv
// Game-memory read port shared by grid_reader (master) and the memory arbiter (slave).
// Handshake: the master raises mem_req with mem_addr; an address is accepted on a rising
// edge where mem_req && mem_gnt, mem_addr holds until then, and mem_data is valid on the
// edge after acceptance. mem_wEn is a write strobe that this reader always drives low.
interface grid_reader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     mem_req;
  logic                     mem_gnt;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_wEn;
  logic [DATA_WIDTH-1:0]    mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wEn,
    input  mem_gnt,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wEn,
    output mem_gnt,
    output mem_data
  );
endinterface

// File: rtl/grid_reader.sv
// Snapshots the game board (200 cells) and four status words from game memory into a
// double-buffered bank; display lookups and status outputs only ever see whole frames.
module grid_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int COLOR_BITS    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  grid_reader_if.master         mem,
  input  logic [4:0]            rd_row,
  input  logic [3:0]            rd_col,
  output logic [COLOR_BITS-1:0] rd_color,
  output logic [31:0]           block,
  output logic [31:0]           level,
  output logic [31:0]           score,
  output logic [31:0]           highestScore,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic                  o_dbg_state
);
  localparam int NUM_CELLS = 200;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_FIRST     = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST_CELL = ADDRESS_WIDTH'(200);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_BLOCK     = ADDRESS_WIDTH'(201);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LEVEL     = ADDRESS_WIDTH'(202);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_SCORE     = ADDRESS_WIDTH'(203);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_HIGH      = ADDRESS_WIDTH'(204);

  typedef enum logic {ST_IDLE = 1'b0, ST_FETCH = 1'b1} state_t;

  state_t                   r_state;
  logic                     r_req;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_cap_valid;
  logic [ADDRESS_WIDTH-1:0] r_cap_addr;
  logic                     r_front_sel;
  logic                     r_busy;
  logic                     r_frame_done;
  logic                     r_overrun;
  logic [31:0]              r_sh_block;
  logic [31:0]              r_sh_level;
  logic [31:0]              r_sh_score;
  logic [31:0]              r_block;
  logic [31:0]              r_level;
  logic [31:0]              r_score;
  logic [31:0]              r_high;
  logic [COLOR_BITS-1:0]    r_bank0 [NUM_CELLS];
  logic [COLOR_BITS-1:0]    r_bank1 [NUM_CELLS];
  logic [COLOR_BITS-1:0]    r_rd_color;

  logic                     w_accept;
  logic                     w_swap;
  logic                     w_cell_wr;
  logic [7:0]               w_cell_idx;
  logic [7:0]               w_rd_idx;
  logic                     w_rd_in_range;
  logic [31:0]              w_status_word;

  assign w_accept      = r_req & mem.mem_gnt;
  assign w_swap        = r_cap_valid && (r_cap_addr == ADDR_HIGH);
  assign w_cell_wr     = r_cap_valid && (r_cap_addr >= ADDR_FIRST) && (r_cap_addr <= ADDR_LAST_CELL);
  assign w_cell_idx    = 8'(r_cap_addr - ADDR_FIRST);
  assign w_rd_idx      = 8'(rd_row) * 8'd10 + 8'(rd_col);
  assign w_rd_in_range = (rd_row < 5'd20) && (rd_col < 4'd10);
  assign w_status_word = 32'(mem.mem_data);

  // Each accepted address is captured on the following edge; the capture of the last
  // status word is also the swap edge, so highestScore loads straight from the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_cap_valid  <= 1'b0;
      r_cap_addr   <= '0;
      r_front_sel  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_sh_block   <= '0;
      r_sh_level   <= '0;
      r_sh_score   <= '0;
      r_block      <= '0;
      r_level      <= '0;
      r_score      <= '0;
      r_high       <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_cap_valid  <= w_accept;
      r_cap_addr   <= r_addr;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
            r_addr  <= ADDR_FIRST;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (frame_start) r_overrun <= 1'b1;
          if (w_accept) begin
            r_addr <= r_addr + ADDRESS_WIDTH'(1);
            if (r_addr == ADDR_HIGH) r_req <= 1'b0;
          end
          if (r_cap_valid) begin
            if (r_cap_addr == ADDR_BLOCK) r_sh_block <= w_status_word;
            if (r_cap_addr == ADDR_LEVEL) r_sh_level <= w_status_word;
            if (r_cap_addr == ADDR_SCORE) r_sh_score <= w_status_word;
          end
          if (w_swap) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_front_sel  <= ~r_front_sel;
            r_block      <= r_sh_block;
            r_level      <= r_sh_level;
            r_score      <= r_sh_score;
            r_high       <= w_status_word;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Cell captures always land in the bank that is not currently front.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else if (w_cell_wr) begin
      if (r_front_sel) r_bank0[w_cell_idx] <= mem.mem_data[COLOR_BITS-1:0];
      else             r_bank1[w_cell_idx] <= mem.mem_data[COLOR_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_color <= '0;
    end else if (!w_rd_in_range) begin
      r_rd_color <= '0;
    end else if (r_front_sel) begin
      r_rd_color <= r_bank1[w_rd_idx];
    end else begin
      r_rd_color <= r_bank0[w_rd_idx];
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wEn   = 1'b0;
  assign rd_color      = r_rd_color;
  assign block         = r_block;
  assign level         = r_level;
  assign score         = r_score;
  assign highestScore  = r_high;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign overrun       = r_overrun;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_grid_reader.sv
// Directed and randomized checks of grid_reader against a frame-level model of the
// game memory: a snapshot is the memory as read at acceptance, visible only after swap.
module tb_grid_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [4:0]  rd_row;
  logic [3:0]  rd_col;
  logic [2:0]  rd_color;
  logic [31:0] block, level, score, highestScore;
  logic        busy, frame_done, overrun, dbg_state;

  grid_reader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) bus ();

  grid_reader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .COLOR_BITS(3)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .mem(bus),
    .rd_row(rd_row), .rd_col(rd_col), .rd_color(rd_color),
    .block(block), .level(level), .score(score), .highestScore(highestScore),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [31:0] gmem [0:4095];
  logic [2:0]  front_exp [200];
  logic [2:0]  pend_cell [200];
  logic [31:0] stat_exp  [4];
  logic [31:0] pend_stat [4];
  logic [11:0] acc_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_done   = 0;

  // Memory responder: registered read of the accepted address.
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_gnt) bus.mem_data <= gmem[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (!reset && bus.mem_req && bus.mem_gnt) acc_q.push_back(bus.mem_addr);
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_color(input int r, input int c);
    if (r < 20 && c < 10) return 32'(front_exp[r*10+c]);
    return 32'd0;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 200; k++) front_exp[k] = '0;
    for (int k = 0; k < 4; k++) stat_exp[k] = '0;
  endtask

  task automatic load_spec_mem();
    for (int k = 0; k < 4096; k++) gmem[k] = 32'(k % 8);
    gmem[201] = 32'd5;
    gmem[202] = 32'd3;
    gmem[203] = 32'd120;
    gmem[204] = 32'd900;
  endtask

  task automatic rd_check(input string tag, input int r, input int c);
    @(negedge clk);
    rd_row = 5'(r);
    rd_col = 4'(c);
    @(posedge clk);
    #1;
    check(tag, 32'(rd_color), exp_color(r, c));
  endtask

  task automatic check_status(input string tag);
    check({tag, "_block"}, block, stat_exp[0]);
    check({tag, "_level"}, level, stat_exp[1]);
    check({tag, "_score"}, score, stat_exp[2]);
    check({tag, "_high"}, highestScore, stat_exp[3]);
  endtask

  task automatic check_accepts(input string tag);
    int ok;
    ok = (acc_q.size() == 204) ? 1 : 0;
    check({tag, "_count"}, acc_q.size(), 204);
    for (int i = 0; i < acc_q.size() && i < 204; i++)
      if (acc_q[i] != 12'(i + 1)) ok = 0;
    check({tag, "_order"}, ok, 1);
  endtask

  // Starts a snapshot and runs until frame_done (returns its cycle number after the start
  // edge), the cycle budget expires (-1), or abort_at is reached (-2, before that edge).
  task automatic run_frame(input int mode, input int fs_at, input int chg_at,
                           input int rd_at, input int abort_at, output int done_cyc);
    int cyc;
    acc_q.delete();
    for (int k = 0; k < 200; k++) pend_cell[k] = gmem[k+1][2:0];
    for (int k = 0; k < 4; k++) pend_stat[k] = gmem[201+k];
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    done_cyc = -1;
    cyc = 0;
    while (done_cyc == -1 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
      frame_start = (cyc == fs_at);
      case (mode)
        0:       bus.mem_gnt = 1'b1;
        1:       bus.mem_gnt = (cyc % 2 == 0);
        default: bus.mem_gnt = 1'($urandom_range(0, 1));
      endcase
      if (cyc == chg_at) gmem[1] = 32'd7;
      if (cyc == abort_at) begin
        done_cyc = -2;
      end else begin
        @(posedge clk);
        #1;
        if (cyc == 1) check("busy_start", busy, 1);
        if (mode == 1 && cyc <= 2) check("hold_addr", bus.mem_addr, cyc);
        if (cyc == rd_at) begin
          check("mid_rd", 32'(rd_color), exp_color(rd_row, rd_col));
          check("mid_block", block, stat_exp[0]);
        end
        if (frame_done === 1'b1) begin
          done_cyc = cyc;
          check("rd_at_swap", 32'(rd_color), exp_color(rd_row, rd_col));
          for (int k = 0; k < 200; k++) front_exp[k] = pend_cell[k];
          for (int k = 0; k < 4; k++) stat_exp[k] = pend_stat[k];
        end
      end
    end
    frame_start = 1'b0;
  endtask

  initial begin
    int dc;
    int base;
    reset       = 1'b1;
    frame_start = 1'b0;
    rd_row      = '0;
    rd_col      = '0;
    bus.mem_gnt = 1'b0;
    load_spec_mem();
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    check("rst_req", bus.mem_req, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wen", bus.mem_wEn, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_color", 32'(rd_color), 0);
    check_status("rst");
    @(negedge clk);
    reset = 1'b0;

    // Full-grant snapshot of the reference memory image.
    run_frame(0, 0, 0, 0, 0, dc);
    check("g1_cycles", dc, 205);
    check("g1_busy_end", busy, 0);
    check("g1_req_end", bus.mem_req, 0);
    check_accepts("g1_acc");
    @(posedge clk);
    #1;
    check("g1_done_pulse", frame_done, 0);
    check_status("g1");
    check("g1_high_value", highestScore, 900);
    rd_check("g1_rd_0_0", 0, 0);
    check("g1_rd_0_0_value", 32'(rd_color), 1);
    rd_check("g1_rd_19_9", 19, 9);
    rd_check("g1_rd_2_3", 2, 3);
    rd_check("rd_row20", 20, 3);
    check("rd_row20_zero", 32'(rd_color), 0);
    rd_check("rd_col12", 4, 12);

    // Grant low on alternating cycles.
    run_frame(1, 0, 0, 0, 0, dc);
    check("alt_cycles", dc, 409);
    check_accepts("alt_acc");
    check_status("alt");
    rd_check("alt_rd_0_0", 0, 0);
    rd_check("alt_rd_19_9", 19, 9);

    // Second frame_start mid-snapshot is dropped and flagged.
    base = n_done;
    run_frame(0, 50, 0, 0, 0, dc);
    check("ovr_cycles", dc, 205);
    check("ovr_set", overrun, 1);
    repeat (300) @(posedge clk);
    #1;
    check("ovr_one_done", n_done - base, 1);
    check("ovr_idle", busy, 0);

    // frame_start on the swap edge is dropped too.
    base = n_done;
    run_frame(0, 205, 0, 0, 0, dc);
    repeat (5) @(posedge clk);
    #1;
    check("swapfs_idle", busy, 0);
    check("swapfs_one_done", n_done - base, 1);

    // Reset 100 cycles into a snapshot.
    rd_check("pre_abort_rd", 0, 0);
    base = n_done;
    run_frame(0, 0, 0, 0, 100, dc);
    reset = 1'b1;
    #1;
    check("abort_req", bus.mem_req, 0);
    check("abort_addr", bus.mem_addr, 0);
    check("abort_busy", busy, 0);
    check("abort_overrun", overrun, 0);
    check("abort_color", 32'(rd_color), 0);
    clear_model();
    check_status("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", n_done - base, 0);
    rd_check("abort_rd_0_0", 0, 0);

    // Fresh snapshot; cell 1 changes after its address is accepted.
    run_frame(0, 0, 3, 100, 0, dc);
    check("chg_cycles", dc, 205);
    check_accepts("chg_acc");
    rd_check("chg_rd_old", 0, 0);
    check("chg_rd_old_value", 32'(rd_color), 1);
    run_frame(0, 0, 0, 0, 0, dc);
    rd_check("chg_rd_new", 0, 0);
    check("chg_rd_new_value", 32'(rd_color), 7);

    // Random memory images with random grants.
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 204; k++) gmem[k] = $urandom;
      run_frame(2, 0, 0, 0, 0, dc);
      check("rand_done", (dc > 0) ? 1 : 0, 1);
      check_accepts("rand_acc");
      check_status("rand");
      for (int j = 0; j < 15; j++)
        rd_check("rand_rd", $urandom_range(0, 22), $urandom_range(0, 12));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/grid_reader.md
GRID_READER -- requirements
Module: grid_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of game-memory words.
REQ-002 Parameter ADDRESS_WIDTH, default 12, game-memory address width.
REQ-003 Parameter COLOR_BITS, default 3, low bits of each cell word kept as colour index.
REQ-004 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port frame_start  input  1  single-cycle request to snapshot game memory.
REQ-007 Port mem_req  output  1  read request to game-memory arbiter.
REQ-008 Port mem_gnt  input  1  arbiter grant; address accepted on an edge where mem_req and mem_gnt are both 1.
REQ-009 Port mem_addr  output  ADDRESS_WIDTH  read address presented to game memory.
REQ-010 Port mem_wEn  output  1  write enable to game memory; constant 0.
REQ-011 Port mem_data  input  DATA_WIDTH  game-memory read data, valid on the edge after acceptance.
REQ-012 Port rd_row  input  5  display cell row, 0..19.
REQ-013 Port rd_col  input  4  display cell column, 0..9.
REQ-014 Port rd_color  output  COLOR_BITS  registered colour of cell (rd_row, rd_col) from front bank.
REQ-015 Ports block, level, score, highestScore  output  32 each  status words from the last completed snapshot.
REQ-016 Port busy  output  1  high while a snapshot is in progress.
REQ-017 Port frame_done  output  1  one-cycle pulse after a snapshot completes and banks swap.
REQ-018 Port overrun  output  1  sticky; set when frame_start arrives while busy.

Function
REQ-019 Memory map: addresses 1..200 hold cells, index = addr-1 = row*10+col; 201 block, 202 level, 203 score, 204 highestScore.
REQ-020 States IDLE and FETCH; IDLE->FETCH on an edge with frame_start=1; FETCH->IDLE on the edge capturing data for address 204.
REQ-021 In FETCH: mem_req=1 until address 204 is accepted, then 0; in IDLE mem_req=0.
REQ-022 mem_addr starts at 1 on FETCH entry, increments by 1 only on acceptance, and holds while mem_gnt=0.
REQ-023 Capture pipeline: data for an accepted address is written on the very next edge regardless of mem_gnt that cycle.
REQ-024 Cell data goes to the back bank (200 x COLOR_BITS) as mem_data[COLOR_BITS-1:0]; status data goes to shadow registers.
REQ-025 On the edge capturing address 204: front/back banks swap, the four status outputs load from shadow, frame_done pulses high for the next cycle only.
REQ-026 With mem_gnt constant 1: start edge E0, acceptances E1..E204, swap at E205; busy high after E0 through the cycle ending at E205.
REQ-027 rd_color updates one cycle after rd_row/rd_col, from the front bank; row>19 or col>9 yields 0.
REQ-028 A rd lookup sampled on the swap edge returns data from the pre-swap front bank.
REQ-029 frame_start while busy is ignored (no queueing) and sets overrun; frame_start on the swap edge is also ignored.
REQ-030 Outputs never show a partially fetched frame; front bank and status change only at swap.

Reset
REQ-031 Reset asynchronously forces IDLE, mem_req=0, mem_addr=0, busy=0, frame_done=0, overrun=0, rd_color=0.
REQ-032 Reset clears both banks, all shadow registers, block/level/score/highestScore to 0, and selects bank 0 as front.
REQ-033 Reset mid-FETCH aborts the snapshot with no swap and no frame_done pulse; the next frame_start after release begins at address 1.

Verification
REQ-034 Memory model cell k = k%8, 201..204 = 5,3,120,900; frame_start, mem_gnt=1 -> frame_done 205 cycles after start; rd (0,0)=1, (19,9)=0, (2,3)=0 (addr 24); block=5, level=3, score=120, highestScore=900.
REQ-035 Same memory, mem_gnt low on alternating cycles -> mem_addr held when ungranted, identical captured values, frame_done at cycle 409.
REQ-036 Second frame_start 50 cycles into a snapshot -> ignored, overrun=1, exactly one frame_done.
REQ-037 Change memory cell 1 to 7 mid-snapshot after address 1 is accepted -> rd (0,0) reads 0 until swap, then old captured value; next snapshot reads 7.
REQ-038 Assert reset at cycle 100 of FETCH -> all outputs 0 immediately, no frame_done, fresh snapshot after release starts at address 1.
REQ-039 rd_row=20 or rd_col=12 -> rd_color=0 one cycle later.
